// File: rtl/jpeg_bl_pkg.sv
// Shared types for the jpeg_decode_nopar block-line stages.
// Coefficient width, lane count and the row-splitter state set.
package jpeg_bl_pkg;
    localparam int W = 9;
    localparam int LANES = 8;
    typedef logic [W-1:0] coef_t;
    typedef enum logic [1:0] {FILL, DRAIN, EOS, DONE} state_t;
endpackage

// File: rtl/bl_row_split8_if.sv
// One _d/_e/_v/_b token stream: data, end-of-stream, valid, back-pressure.
// The producer side is master, the consumer side is slave.
interface bl_row_split8_if;
    import jpeg_bl_pkg::*;
    coef_t d;
    logic  e;
    logic  v;
    logic  b;
    modport master (output d, e, v, input b);
    modport slave (input d, e, v, output b);
endinterface

// File: rtl/bl_row_buf8.sv
// One 8-coefficient row register with its per-lane pending mask.
// Load sets all pending bits; while selected, each lane clears on its transfer.
module bl_row_buf8
    import jpeg_bl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic              pad,
    input  logic [2:0]        col,
    input  coef_t             wd,
    input  logic              load,
    input  logic              sel,
    input  logic [LANES-1:0]  lane_b,
    output coef_t [LANES-1:0] row,
    output logic [LANES-1:0]  pend
);
    always_ff @(posedge clock) begin
        if (reset) begin
            row  <= '0;
            pend <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (wr && col == 3'(k))
                    row[k] <= wd;
                else if (pad && 3'(k) >= col)
                    row[k] <= '0;
            end
            if (load)
                pend <= '1;
            else if (sel)
                pend <= pend & lane_b;
        end
    end
endmodule

// File: rtl/bl_row_split8.sv
// Serial-to-8-lane row splitter feeding the IDCT row butterfly.
// BL_ROW_SPLIT8_PINGPONG_EN selects a double row buffer for full throughput.
module bl_row_split8
    import jpeg_bl_pkg::*;
(
    input logic            clock,
    input logic            reset,
    bl_row_split8_if.slave i,
    bl_row_split8_if.master a,
    bl_row_split8_if.master b,
    bl_row_split8_if.master c,
    bl_row_split8_if.master d,
    bl_row_split8_if.master e,
    bl_row_split8_if.master f,
    bl_row_split8_if.master g,
    bl_row_split8_if.master h
);
    state_t            state;
    logic [2:0]        col;
    logic              up;
    logic              stall;
    logic              acc;
    logic              fin;
    logic              lane_e;
    logic [LANES-1:0]  lane_b;
    logic [LANES-1:0]  lp;
    logic [LANES-1:0]  lp_nxt;
    coef_t [LANES-1:0] lane_d;

    assign lane_b = {h.b, g.b, f.b, e.b, d.b, c.b, b.b, a.b};
    assign {a.d, a.e, a.v} = {lane_d[0], lane_e, lp[0]};
    assign {b.d, b.e, b.v} = {lane_d[1], lane_e, lp[1]};
    assign {c.d, c.e, c.v} = {lane_d[2], lane_e, lp[2]};
    assign {d.d, d.e, d.v} = {lane_d[3], lane_e, lp[3]};
    assign {e.d, e.e, e.v} = {lane_d[4], lane_e, lp[4]};
    assign {f.d, f.e, f.v} = {lane_d[5], lane_e, lp[5]};
    assign {g.d, g.e, g.v} = {lane_d[6], lane_e, lp[6]};
    assign {h.d, h.e, h.v} = {lane_d[7], lane_e, lp[7]};

    assign i.b    = stall;
    assign acc    = i.v & ~stall;
    assign lane_e = (state == EOS);
    assign lp_nxt = lp & lane_b;

`ifdef BL_ROW_SPLIT8_PINGPONG_EN
    logic [LANES-1:0]  pend [2];
    coef_t [LANES-1:0] row [2];
    logic [1:0]        wt;
    logic [1:0]        wr;
    logic [1:0]        pad;
    logic [1:0]        load;
    logic              wsel;
    logic              hsel;
    logic              lsel;
    logic              idle;
    logic              open;
    logic              hand;
    logic              eos_go;

    // wsel fills, hsel is next to hand over, lsel is on the lanes
    assign lp     = pend[lsel];
    assign idle   = (lp_nxt == '0);
    assign open   = ~wt[wsel] & (pend[wsel] == '0);
    assign stall  = ~up | (state != FILL) | ~open;
    assign fin    = acc & (i.e ? (col != 3'd0) : (col == 3'd7));
    assign hand   = (state inside {FILL, DRAIN}) & idle
                  & (wt[hsel] | (fin & (wsel == hsel)));
    assign eos_go = (state == DRAIN) & idle & (wt == 2'b00);

    always_comb begin
        lane_d = '0;
        if (lp != '0 && state != EOS)
            lane_d = row[lsel];
    end

    for (genvar k = 0; k < 2; k++) begin : g_buf
        assign wr[k]   = acc & ~i.e & (wsel == 1'(k));
        assign pad[k]  = acc & i.e & (wsel == 1'(k));
        assign load[k] = (hand & (hsel == 1'(k)))
                       | (eos_go & (lsel == 1'(k)));
        bl_row_buf8 u_buf (
            .clock  (clock),
            .reset  (reset),
            .wr     (wr[k]),
            .pad    (pad[k]),
            .col    (col),
            .wd     (i.d),
            .load   (load[k]),
            .sel    (lsel == 1'(k)),
            .lane_b (lane_b),
            .row    (row[k]),
            .pend   (pend[k])
        );
    end

    // DRAIN here means an EOS is waiting for both buffers to empty
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
            col   <= '0;
            up    <= 1'b0;
            wt    <= '0;
            wsel  <= 1'b0;
            hsel  <= 1'b0;
            lsel  <= 1'b0;
        end else begin
            up <= 1'b1;
            if (acc)
                col <= (i.e || col == 3'd7) ? 3'd0 : col + 3'd1;
            if (fin) begin
                wt[wsel] <= 1'b1;
                wsel     <= ~wsel;
            end
            if (hand) begin
                wt[hsel] <= 1'b0;
                hsel     <= ~hsel;
                lsel     <= hsel;
            end
            unique case (state)
                FILL:  if (acc && i.e) state <= DRAIN;
                DRAIN: if (eos_go) state <= EOS;
                EOS:   if (idle) state <= DONE;
                DONE:  ;
            endcase
        end
    end
`else
    logic [LANES-1:0]  pend;
    coef_t [LANES-1:0] row;
    logic              eos_seen;
    logic              wr;
    logic              pad;
    logic              load;

    assign lp    = pend;
    assign stall = ~up | (state != FILL);
    assign fin   = acc & (i.e | (col == 3'd7));
    assign wr    = acc & ~i.e;
    assign pad   = acc & i.e;
    assign load  = fin | (state == DRAIN && lp_nxt == '0 && eos_seen);

    always_comb begin
        lane_d = '0;
        if (state == DRAIN)
            lane_d = row;
    end

    bl_row_buf8 u_buf (
        .clock  (clock),
        .reset  (reset),
        .wr     (wr),
        .pad    (pad),
        .col    (col),
        .wd     (i.d),
        .load   (load),
        .sel    (1'b1),
        .lane_b (lane_b),
        .row    (row),
        .pend   (pend)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FILL;
            col      <= '0;
            up       <= 1'b0;
            eos_seen <= 1'b0;
        end else begin
            up <= 1'b1;
            unique case (state)
                FILL: if (acc) begin
                    col <= fin ? 3'd0 : col + 3'd1;
                    if (i.e)
                        eos_seen <= 1'b1;
                    if (i.e && col == 3'd0)
                        state <= EOS;
                    else if (fin)
                        state <= DRAIN;
                end
                DRAIN: if (lp_nxt == '0) state <= eos_seen ? EOS : FILL;
                EOS:   if (lp_nxt == '0) state <= DONE;
                DONE:  ;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_bl_row_split8.sv
// Directed vector bench for bl_row_split8.
// Each vector drives one cycle of inputs and checks the outputs after the edge.
module tb_bl_row_split8;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] lbv;
    logic [7:0] gv;
    logic [7:0] ge;
    logic [71:0] gd;
    int nvec = 0;
    int nbad = 0;

    always #5 clock = ~clock;

    bl_row_split8_if in_if ();
    bl_row_split8_if a_if ();
    bl_row_split8_if b_if ();
    bl_row_split8_if c_if ();
    bl_row_split8_if d_if ();
    bl_row_split8_if e_if ();
    bl_row_split8_if f_if ();
    bl_row_split8_if g_if ();
    bl_row_split8_if h_if ();

    bl_row_split8 dut (
        .clock (clock),
        .reset (reset),
        .i     (in_if),
        .a     (a_if),
        .b     (b_if),
        .c     (c_if),
        .d     (d_if),
        .e     (e_if),
        .f     (f_if),
        .g     (g_if),
        .h     (h_if)
    );

    assign {h_if.b, g_if.b, f_if.b, e_if.b} = lbv[7:4];
    assign {d_if.b, c_if.b, b_if.b, a_if.b} = lbv[3:0];
    assign gv = {h_if.v, g_if.v, f_if.v, e_if.v, d_if.v, c_if.v, b_if.v, a_if.v};
    assign ge = {h_if.e, g_if.e, f_if.e, e_if.e, d_if.e, c_if.e, b_if.e, a_if.e};
    assign gd = {h_if.d, g_if.d, f_if.d, e_if.d, d_if.d, c_if.d, b_if.d, a_if.d};

    typedef struct {
        string       nm;
        bit          rst;
        bit          iv;
        bit          ie;
        logic [8:0]  id;
        logic [7:0]  lb;
        logic        xb;
        logic [7:0]  xv;
        logic [7:0]  xe;
        logic [71:0] xd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, bit rst, bit iv, bit ie,
                                logic [8:0] id, logic [7:0] lb, logic xb,
                                logic [7:0] xv, logic [7:0] xe, logic [71:0] xd);
        vec_t t;
        t.nm = nm; t.rst = rst; t.iv = iv; t.ie = ie; t.id = id; t.lb = lb;
        t.xb = xb; t.xv = xv; t.xe = xe; t.xd = xd;
        return t;
    endfunction

    // Lane a sits in the low bits
    function automatic logic [71:0] row8(input int base);
        logic [71:0] r;
        for (int k = 0; k < 8; k++)
            r[9*k +: 9] = 9'(base + k + 1);
        return r;
    endfunction

    function automatic void push_row(input int base);
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk("fill", 0, 1, 0, 9'(base + k), 8'h00, k == 8,
                             (k == 8) ? 8'hFF : 8'h00, 8'h00,
                             (k == 8) ? row8(base) : 72'd0));
    endfunction

    task automatic apply(input vec_t t);
        reset    = t.rst;
        in_if.v  = t.iv;
        in_if.e  = t.ie;
        in_if.d  = t.id;
        lbv      = t.lb;
        @(posedge clock);
        #1;
        nvec++;
        if ({in_if.b, gv, ge, gd} !== {t.xb, t.xv, t.xe, t.xd}) begin
            nbad++;
            $display("FAIL %s: got i_b=%b v=%h e=%h d=%h, want i_b=%b v=%h e=%h d=%h",
                     t.nm, in_if.b, gv, ge, gd, t.xb, t.xv, t.xe, t.xd);
        end
    endtask

    initial begin
        logic [71:0] r3;
        r3 = '0;
        r3[8:0]   = 9'h1FF;
        r3[17:9]  = 9'h100;
        r3[26:18] = 9'h0AA;
`ifdef BL_ROW_SPLIT8_PINGPONG_EN
        tbl.push_back(mk("rst", 1, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("wake", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        foreach (tbl[n]) apply(tbl[n]);
        // 16 back-to-back tokens, lanes free
        for (int k = 1; k <= 16; k++)
            apply(mk("pp_free", 0, 1, 0, 9'(k), 8'h00, 0,
                     (k == 8 || k == 16) ? 8'hFF : 8'h00, 8'h00,
                     (k == 8) ? row8(0) : (k == 16) ? row8(8) : 72'd0));
        apply(mk("pp_idle", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        apply(mk("pp_rst", 1, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        apply(mk("pp_wake", 0, 0, 0, 9'h0, 8'hFF, 0, 8'h00, 8'h00, 72'd0));
        // Lanes stalled: both buffers fill, then back-pressure
        for (int k = 1; k <= 16; k++)
            apply(mk("pp_stall", 0, 1, 0, 9'(k), 8'hFF, k == 16,
                     (k >= 8) ? 8'hFF : 8'h00, 8'h00,
                     (k >= 8) ? row8(0) : 72'd0));
        apply(mk("pp_full", 0, 1, 0, 9'd99, 8'hFF, 1, 8'hFF, 8'h00, row8(0)));
        apply(mk("pp_rel", 0, 1, 0, 9'd99, 8'h00, 0, 8'hFF, 8'h00, row8(8)));
        apply(mk("pp_empty", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        apply(mk("pp_eos", 0, 1, 1, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        apply(mk("pp_eos_lanes", 0, 0, 0, 9'h0, 8'h00, 1, 8'hFF, 8'hFF, 72'd0));
        apply(mk("pp_done", 0, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
`else
        // Reset, then a first token offered while i_b is still high
        tbl.push_back(mk("rst", 1, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("wake", 0, 1, 0, 9'h001, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        push_row(0);
        tbl.push_back(mk("drain", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        // Lane c held off for five cycles
        push_row(16);
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk("stall_c", 0, 0, 0, 9'h0, 8'h04, 1, 8'h04, 8'h00, row8(16)));
        tbl.push_back(mk("release_c", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        // Partial row closed by EOS: padded row, then eos on all lanes
        tbl.push_back(mk("part1", 0, 1, 0, 9'h1FF, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("part2", 0, 1, 0, 9'h100, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("part3", 0, 1, 0, 9'h0AA, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("part_eos", 0, 1, 1, 9'h155, 8'h00, 1, 8'hFF, 8'h00, r3));
        tbl.push_back(mk("eos_lanes", 0, 0, 0, 9'h0, 8'h00, 1, 8'hFF, 8'hFF, 72'd0));
        tbl.push_back(mk("done", 0, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("done_hold", 0, 1, 0, 9'h077, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        // EOS exactly on a row boundary: no padded row
        tbl.push_back(mk("rst2", 1, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("wake2", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        push_row(32);
        tbl.push_back(mk("drain2", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        tbl.push_back(mk("bound_eos", 0, 1, 1, 9'h0, 8'h00, 1, 8'hFF, 8'hFF, 72'd0));
        tbl.push_back(mk("eos_part", 0, 0, 0, 9'h0, 8'hF0, 1, 8'hF0, 8'hFF, 72'd0));
        tbl.push_back(mk("bound_done", 0, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        foreach (tbl[n]) apply(tbl[n]);

        // Reset while lanes b,d,e,g still owe a transfer
        apply(mk("rst3", 1, 0, 0, 9'h0, 8'h00, 1, 8'h00, 8'h00, 72'd0));
        apply(mk("wake3", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        for (int k = 1; k <= 8; k++)
            apply(mk("fill5", 0, 1, 0, 9'(48 + k), 8'h00, k == 8,
                     (k == 8) ? 8'hFF : 8'h00, 8'h00,
                     (k == 8) ? row8(48) : 72'd0));
        apply(mk("pend_5a", 0, 0, 0, 9'h0, 8'h5A, 1, 8'h5A, 8'h00, row8(48)));
        apply(mk("mid_rst", 1, 0, 0, 9'h0, 8'h5A, 1, 8'h00, 8'h00, 72'd0));
        apply(mk("post_rst", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
        for (int k = 1; k <= 8; k++)
            apply(mk("fresh", 0, 1, 0, 9'(64 + k), 8'h00, k == 8,
                     (k == 8) ? 8'hFF : 8'h00, 8'h00,
                     (k == 8) ? row8(64) : 72'd0));
        apply(mk("fresh_drain", 0, 0, 0, 9'h0, 8'h00, 0, 8'h00, 8'h00, 72'd0));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
